// File: rtl/modulador_pkg.sv
// Shared types and constants for the modulator frame sequencer.
// One modulator byte lasts BITS_PER_BYTE * SAMPLES_PER_BIT clocks.
package modulador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      SYNC = 2'd2,
      DATA = 2'd3
   } ctrl_state_t;

   localparam logic [7:0] PREAMBLE_BYTE     = 8'h55;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hD3;
   localparam logic [7:0] DEFAULT_FILL_BYTE = 8'h00;
   localparam int         SAMPLES_PER_BIT   = 32;
   localparam int         BITS_PER_BYTE     = 8;

endpackage

// File: rtl/modulador_ctrl_byte_fifo.sv
// Synchronous FIFO for {last, data} payload entries.
// A push while full is taken only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_full    = (o_count == DEPTH_C);
   assign o_empty   = (o_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/modulador_ctrl.sv
// Frame sequencer: buffers host payload and feeds the modulator
// preamble, sync and payload bytes, one per end-of-byte strobe.
module modulador_ctrl
   import modulador_pkg::*;
#(
   parameter int         FIFO_DEPTH   = 4,
   parameter int         PREAMBLE_LEN = 2,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter logic [7:0] FILL_BYTE    = DEFAULT_FILL_BYTE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] tx_byte,
   output logic       tx_en,
   input  logic       byte_done,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   localparam int         CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0] PRE_LEN = 4'(PREAMBLE_LEN);

   ctrl_state_t   r_state;
   logic [3:0]    r_pre_cnt;
   logic          r_cur_last;
   logic [7:0]    r_tx_byte;
   logic          r_tx_en;
   logic          r_busy;
   logic          r_frame_done;
   logic          r_underrun;

   logic          w_push;
   logic          w_pop;
   logic [8:0]    w_head;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;

   // Pops only on strobes that load payload: leaving SYNC, or mid-frame in DATA.
   assign w_pop    = byte_done && !w_empty &&
                     ((r_state == SYNC) || ((r_state == DATA) && !r_cur_last));
   assign in_ready = !w_full || w_pop;
   assign w_push   = in_valid && in_ready;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata ({in_last, in_data}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pre_cnt    <= '0;
         r_cur_last   <= 1'b0;
         r_tx_byte    <= 8'h00;
         r_tx_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_count != '0) begin
                  r_state   <= PRE;
                  r_tx_byte <= PREAMBLE_BYTE;
                  r_pre_cnt <= 4'd1;
                  r_tx_en   <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            PRE: begin
               if (byte_done) begin
                  if (r_pre_cnt == PRE_LEN) begin
                     r_state   <= SYNC;
                     r_tx_byte <= SYNC_BYTE;
                  end else begin
                     r_pre_cnt <= r_pre_cnt + 4'd1;
                  end
               end
            end
            SYNC, DATA: begin
               if (byte_done) begin
                  if ((r_state == DATA) && r_cur_last) begin
                     r_state      <= IDLE;
                     r_tx_byte    <= 8'h00;
                     r_tx_en      <= 1'b0;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_state <= DATA;
                     if (!w_empty) begin
                        r_tx_byte  <= w_head[7:0];
                        r_cur_last <= w_head[8];
                     end else begin
                        // Starved mid-frame: keep the carrier busy with filler.
                        r_tx_byte  <= FILL_BYTE;
                        r_cur_last <= 1'b0;
                        r_underrun <= 1'b1;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_byte    = r_tx_byte;
   assign tx_en      = r_tx_en;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign underrun   = r_underrun;

endmodule

// File: tb/tb_modulador_ctrl.sv
// Bench for modulador_ctrl: frame-position model plus directed frames.
module tb_modulador_ctrl;

   localparam int         DEPTH = 4;
   localparam int         PL    = 2;
   localparam logic [7:0] SYNCB = 8'hD3;
   localparam logic [7:0] FILLB = 8'h00;
   localparam int         GAP   = 255;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_valid = 1'b0;
   logic       byte_done = 1'b0;
   logic       in_ready;
   logic [7:0] tx_byte;
   logic       tx_en;
   logic       busy;
   logic       frame_done;
   logic       underrun;

   always #5 clk = ~clk;

   modulador_ctrl #(
      .FIFO_DEPTH   (DEPTH),
      .PREAMBLE_LEN (PL),
      .SYNC_BYTE    (SYNCB),
      .FILL_BYTE    (FILLB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_byte    (tx_byte),
      .tx_en      (tx_en),
      .byte_done  (byte_done),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the frame is a byte sequence indexed by position m_k
   // (0..PL-1 preamble, PL sync, >PL payload slots).
   logic [8:0] mq[$];
   bit         m_air  = 1'b0;
   int         m_k    = 0;
   bit         m_last = 1'b0;
   logic [7:0] m_tx   = 8'h00;
   bit         m_fd   = 1'b0;
   bit         m_ur   = 1'b0;

   function automatic bit m_takes_payload();
      return m_air && byte_done && (m_k >= PL) && !((m_k > PL) && m_last);
   endfunction

   function automatic bit m_pop();
      return m_takes_payload() && (mq.size() > 0);
   endfunction

   function automatic bit m_ready();
      return (mq.size() < DEPTH) || m_pop();
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_air = 0; m_k = 0; m_last = 0; m_tx = 8'h00; m_fd = 0; m_ur = 0;
         end else begin
            bit         pop_now;
            bit         push_now;
            logic [8:0] wr;
            pop_now  = m_pop();
            push_now = in_valid && m_ready();
            wr       = {in_last, in_data};
            m_fd = 0;
            m_ur = 0;
            if (!m_air) begin
               if (mq.size() > 0) begin
                  m_air = 1; m_k = 0; m_tx = 8'h55;
               end
            end else if (byte_done) begin
               if (m_k < PL - 1) begin
                  m_k++; m_tx = 8'h55;
               end else if (m_k == PL - 1) begin
                  m_k++; m_tx = SYNCB;
               end else if ((m_k > PL) && m_last) begin
                  m_air = 0; m_tx = 8'h00; m_fd = 1;
               end else begin
                  m_k++;
                  if (pop_now) begin
                     logic [8:0] h;
                     h = mq.pop_front();
                     m_tx = h[7:0]; m_last = h[8];
                  end else begin
                     m_tx = FILLB; m_last = 0; m_ur = 1;
                  end
               end
            end
            if (push_now) mq.push_back(wr);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("tx_byte",    tx_byte,    m_tx);
         chk("tx_en",      8'(tx_en),      8'(m_air));
         chk("busy",       8'(busy),       8'(m_air));
         chk("frame_done", 8'(frame_done), 8'(m_fd));
         chk("underrun",   8'(underrun),   8'(m_ur));
         chk("in_ready",   8'(in_ready),   8'(m_ready()));
      end
   end

   // Host: presents queued bytes one at a time, holds until accepted.
   logic [8:0] hq[$];
   bit         acc;
   initial begin
      forever begin
         @(negedge clk);
         acc = in_valid && in_ready && rst_n;
         @(posedge clk);
         #1;
         if (acc) begin
            void'(hq.pop_front());
            in_valid = 1'b0;
         end
         if (!in_valid && hq.size() > 0) begin
            {in_last, in_data} = hq[0];
            in_valid = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int gap);
      repeat (gap) tick();
      byte_done = 1'b1;
      tick();
      byte_done = 1'b0;
   endtask

   initial begin
      #2_000_000;
      n_cmp++;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected test completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      logic [7:0] seq2 [5];
      seq2 = '{8'h55, 8'hD3, 8'h01, 8'h02, 8'h03};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst tx_byte",  tx_byte,        8'h00);
      chk("rst tx_en",    8'(tx_en),      8'h00);
      chk("rst busy",     8'(busy),       8'h00);
      chk("rst in_ready", 8'(in_ready),   8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      // Single-byte frame
      hq.push_back({1'b1, 8'hA5});
      repeat (4) tick();
      chk("t1 busy", 8'(busy), 8'h01);
      chk("t1 pre0", tx_byte, 8'h55);
      pulse(GAP); chk("t1 pre1", tx_byte, 8'h55);
      pulse(GAP); chk("t1 sync", tx_byte, 8'hD3);
      pulse(GAP); chk("t1 data", tx_byte, 8'hA5);
      pulse(GAP);
      chk("t1 frame_done", 8'(frame_done), 8'h01);
      chk("t1 tx_en off",  8'(tx_en),      8'h00);
      chk("t1 tx_byte 0",  tx_byte,        8'h00);
      tick();
      chk("t1 fd pulse", 8'(frame_done), 8'h00);
      repeat (4) tick();

      // Three-byte frame pushed back-to-back
      hq.push_back({1'b0, 8'h01});
      hq.push_back({1'b0, 8'h02});
      hq.push_back({1'b1, 8'h03});
      repeat (6) tick();
      for (int i = 0; i < 5; i++) begin
         pulse(GAP);
         chk("t2 seq", tx_byte, seq2[i]);
         chk("t2 no underrun", 8'(underrun), 8'h00);
      end
      pulse(GAP);
      chk("t2 frame_done", 8'(frame_done), 8'h01);
      repeat (4) tick();

      // Five pushes into a four-deep FIFO
      hq.push_back({1'b0, 8'h20});
      hq.push_back({1'b0, 8'h21});
      hq.push_back({1'b0, 8'h22});
      hq.push_back({1'b0, 8'h23});
      hq.push_back({1'b1, 8'h24});
      repeat (10) tick();
      chk("t3 full in_ready", 8'(in_ready), 8'h00);
      chk("t3 host waiting",  8'(hq.size()), 8'h01);
      pulse(GAP); pulse(GAP); pulse(GAP);
      chk("t3 first data", tx_byte, 8'h20);
      tick();
      chk("t3 fifth taken", 8'(hq.size()), 8'h00);
      for (int i = 1; i < 5; i++) begin
         pulse(GAP);
         chk("t3 seq", tx_byte, 8'(8'h20 + i));
      end
      pulse(GAP);
      chk("t3 frame_done", 8'(frame_done), 8'h01);
      repeat (4) tick();

      // Underrun mid-frame
      hq.push_back({1'b0, 8'h30});
      repeat (4) tick();
      pulse(GAP); pulse(GAP); pulse(GAP);
      chk("t4 first", tx_byte, 8'h30);
      pulse(GAP);
      chk("t4 fill",     tx_byte,        8'h00);
      chk("t4 underrun", 8'(underrun),   8'h01);
      chk("t4 tx_en on", 8'(tx_en),      8'h01);
      tick();
      chk("t4 underrun pulse", 8'(underrun), 8'h00);
      hq.push_back({1'b1, 8'h31});
      repeat (5) tick();
      pulse(GAP);
      chk("t4 second", tx_byte, 8'h31);
      chk("t4 no underrun", 8'(underrun), 8'h00);
      pulse(GAP);
      chk("t4 frame_done", 8'(frame_done), 8'h01);
      repeat (4) tick();

      // Asynchronous reset during DATA with two entries queued
      hq.push_back({1'b0, 8'h40});
      hq.push_back({1'b0, 8'h41});
      hq.push_back({1'b1, 8'h42});
      repeat (6) tick();
      pulse(GAP); pulse(GAP); pulse(GAP);
      chk("t5 in data", tx_byte, 8'h40);
      repeat (20) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5 async tx_en",   8'(tx_en), 8'h00);
      chk("t5 async tx_byte", tx_byte,   8'h00);
      chk("t5 async busy",    8'(busy),  8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t5 in_ready", 8'(in_ready), 8'h01);
      repeat (5) tick();
      chk("t5 fifo empty idle", 8'(busy), 8'h00);

      // byte_done while idle and empty
      pulse(3); pulse(3); pulse(3);
      chk("t6 busy",    8'(busy),  8'h00);
      chk("t6 tx_byte", tx_byte,   8'h00);
      chk("t6 tx_en",   8'(tx_en), 8'h00);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
